// File: rtl/mem_cache_pkg.sv
// Shared types and helpers for the write-back data cache: FSM state encoding,
// word/byte-select widths and the byte-lane functions used on the CPU side.
package mem_cache_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } cache_state_e;

    // Zero-extended byte picked out of a word by the low address bits
    function automatic logic [WORD_W-1:0] byte_extract(input logic [WORD_W-1:0] word,
                                                       input logic [BYTE_SEL_W-1:0] sel);
        logic [WORD_W-1:0] res;
        case (sel)
            2'd0:    res = {24'd0, word[7:0]};
            2'd1:    res = {24'd0, word[15:8]};
            2'd2:    res = {24'd0, word[23:16]};
            2'd3:    res = {24'd0, word[31:24]};
            default: res = {24'd0, word[7:0]};
        endcase
        return res;
    endfunction

    function automatic logic [3:0] byte_enable(input logic is_word,
                                               input logic [BYTE_SEL_W-1:0] sel);
        logic [3:0] be;
        if (is_word) begin
            be = 4'b1111;
        end else begin
            case (sel)
                2'd0:    be = 4'b0001;
                2'd1:    be = 4'b0010;
                2'd2:    be = 4'b0100;
                2'd3:    be = 4'b1000;
                default: be = 4'b0001;
            endcase
        end
        return be;
    endfunction

endpackage

// File: rtl/mem_wb_cache_ctrl_if.sv
// Bus bundles for the cache: CPU-side (MEM stage) request port and the
// memory-side per-word beat port. Master drives requests, slave answers.
interface cpu_bus_if
    import mem_cache_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_is_word;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_wdata;
    logic [WORD_W-1:0] cpu_rdata;
    logic              cpu_ready;

    modport master (output cpu_req, cpu_we, cpu_is_word, cpu_addr, cpu_wdata,
                    input  cpu_rdata, cpu_ready);
    modport slave  (input  cpu_req, cpu_we, cpu_is_word, cpu_addr, cpu_wdata,
                    output cpu_rdata, cpu_ready);
endinterface

interface mem_bus_if
    import mem_cache_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ready);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_cache_array.sv
// Direct-mapped cache storage: tag/valid/dirty per line plus line data, with
// asynchronous read and byte-enabled synchronous write. Only valid/dirty reset.
module mem_cache_array
    import mem_cache_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 22,
    parameter int IDX_W      = 6,
    parameter int WSEL_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WSEL_W-1:0] word,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [WORD_W-1:0] rd_data,
    input  logic              data_we,
    input  logic [3:0]        data_be,
    input  logic [WORD_W-1:0] data_wdata,
    input  logic              meta_we,
    input  logic [TAG_W-1:0]  meta_tag,
    input  logic              set_dirty
);

    logic [WORD_W-1:0] data_mem [LINES][LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid_r;
    logic [LINES-1:0]  dirty_r;

    assign rd_tag   = tag_mem[idx];
    assign rd_valid = valid_r[idx];
    assign rd_dirty = dirty_r[idx];
    assign rd_data  = data_mem[idx][word];

    // Byte-lane data write
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (data_we && data_be[b]) begin
                data_mem[idx][word][8*b +: 8] <= data_wdata[8*b +: 8];
            end
        end
    end

    // Tag capture at the end of a refill
    always_ff @(posedge clk) begin
        if (meta_we) begin
            tag_mem[idx] <= meta_tag;
        end
    end

    // Line state: a completed refill leaves the line valid and clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (meta_we) begin
            valid_r[idx] <= 1'b1;
            dirty_r[idx] <= 1'b0;
        end else if (set_dirty) begin
            dirty_r[idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_wb_cache_ctrl.sv
// Direct-mapped write-back data cache controller for the MEM stage: hit path,
// dirty-victim writeback and line refill. Define CACHE_STATS_EN for hit/miss counters.
module mem_wb_cache_ctrl
    import mem_cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    cpu_bus_if.slave    cpu,
    mem_bus_if.master   mem
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int WSEL_W  = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W   = $clog2(LINES);
    localparam int IDX_LSB = BYTE_SEL_W + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;
    localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(LINE_WORDS - 1);

    cache_state_e      state_r;
    cache_state_e      state_s;
    logic [WSEL_W-1:0] beat_r;
    logic [IDX_W-1:0]  miss_idx_r;
    logic [TAG_W-1:0]  miss_tag_r;

    logic [IDX_W-1:0]  cpu_idx_s;
    logic [TAG_W-1:0]  cpu_tag_s;
    logic [WSEL_W-1:0] cpu_off_s;
    logic [IDX_W-1:0]  arr_idx_s;
    logic [WSEL_W-1:0] arr_word_s;
    logic              hit_s;
    logic              miss_s;
    logic              last_beat_s;

    logic [TAG_W-1:0]  rd_tag_s;
    logic              rd_valid_s;
    logic              rd_dirty_s;
    logic [WORD_W-1:0] rd_data_s;
    logic              data_we_s;
    logic [3:0]        data_be_s;
    logic [WORD_W-1:0] data_wdata_s;
    logic              meta_we_s;
    logic              set_dirty_s;

    logic              cpu_ready_s;
    logic [WORD_W-1:0] cpu_rdata_s;
    logic              mem_req_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [WORD_W-1:0] mem_wdata_s;

    assign cpu_idx_s = cpu.cpu_addr[IDX_LSB +: IDX_W];
    assign cpu_tag_s = cpu.cpu_addr[TAG_LSB +: TAG_W];

    generate
        if (OFF_W > 0) begin : g_word_off
            assign cpu_off_s = cpu.cpu_addr[BYTE_SEL_W +: WSEL_W];
        end else begin : g_single_word
            assign cpu_off_s = '0;
        end
    endgenerate

    // While a miss is in flight the array is steered by the latched line and the beat
    assign arr_idx_s   = (state_r == IDLE) ? cpu_idx_s : miss_idx_r;
    assign arr_word_s  = (state_r == IDLE) ? cpu_off_s : beat_r;
    assign hit_s       = (state_r == IDLE) && cpu.cpu_req && rd_valid_s && (rd_tag_s == cpu_tag_s);
    assign miss_s      = (state_r == IDLE) && cpu.cpu_req && !hit_s;
    assign last_beat_s = (beat_r == LAST_BEAT);

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0]  tag,
                                                    input logic [IDX_W-1:0]  idx,
                                                    input logic [WSEL_W-1:0] beat);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[BYTE_SEL_W +: WSEL_W] = beat;
        a[IDX_LSB +: IDX_W]     = idx;
        a[TAG_LSB +: TAG_W]     = tag;
        return a;
    endfunction

    mem_cache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX_W),
        .WSEL_W     (WSEL_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (arr_idx_s),
        .word       (arr_word_s),
        .rd_tag     (rd_tag_s),
        .rd_valid   (rd_valid_s),
        .rd_dirty   (rd_dirty_s),
        .rd_data    (rd_data_s),
        .data_we    (data_we_s),
        .data_be    (data_be_s),
        .data_wdata (data_wdata_s),
        .meta_we    (meta_we_s),
        .meta_tag   (miss_tag_r),
        .set_dirty  (set_dirty_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_s) begin
                    if (rd_valid_s && rd_dirty_s) begin
                        state_s = WRITEBACK;
                    end else begin
                        state_s = REFILL;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITEBACK: begin
                if (mem.mem_ready && last_beat_s) begin
                    state_s = REFILL;
                end else begin
                    state_s = WRITEBACK;
                end
            end
            REFILL: begin
                if (mem.mem_ready && last_beat_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = REFILL;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Beat counter and miss-line capture; the line is latched so a dropped request cannot retarget the burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_r     <= '0;
            miss_idx_r <= '0;
            miss_tag_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    beat_r <= '0;
                    if (miss_s) begin
                        miss_idx_r <= cpu_idx_s;
                        miss_tag_r <= cpu_tag_s;
                    end
                end
                WRITEBACK, REFILL: begin
                    if (mem.mem_ready) begin
                        beat_r <= last_beat_s ? '0 : beat_r + WSEL_W'(1);
                    end
                end
                default: beat_r <= '0;
            endcase
        end
    end

    // FSM outputs: CPU response, memory beat and array write controls
    always_comb begin
        cpu_ready_s  = 1'b0;
        cpu_rdata_s  = '0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = '0;
        mem_wdata_s  = '0;
        data_we_s    = 1'b0;
        data_be_s    = 4'b0000;
        data_wdata_s = '0;
        meta_we_s    = 1'b0;
        set_dirty_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cpu_ready_s = hit_s;
                if (hit_s && !cpu.cpu_we) begin
                    cpu_rdata_s = cpu.cpu_is_word ? rd_data_s
                                : byte_extract(rd_data_s, cpu.cpu_addr[BYTE_SEL_W-1:0]);
                end else begin
                    cpu_rdata_s = '0;
                end
                data_we_s    = hit_s && cpu.cpu_we;
                set_dirty_s  = hit_s && cpu.cpu_we;
                data_be_s    = byte_enable(cpu.cpu_is_word, cpu.cpu_addr[BYTE_SEL_W-1:0]);
                data_wdata_s = cpu.cpu_is_word ? cpu.cpu_wdata : {4{cpu.cpu_wdata[7:0]}};
            end
            WRITEBACK: begin
                mem_req_s   = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = beat_addr(rd_tag_s, miss_idx_r, beat_r);
                mem_wdata_s = rd_data_s;
            end
            REFILL: begin
                mem_req_s    = 1'b1;
                mem_addr_s   = beat_addr(miss_tag_r, miss_idx_r, beat_r);
                data_we_s    = mem.mem_ready;
                data_be_s    = 4'b1111;
                data_wdata_s = mem.mem_rdata;
                meta_we_s    = mem.mem_ready && last_beat_s;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    assign cpu.cpu_ready = cpu_ready_s;
    assign cpu.cpu_rdata = cpu_rdata_s;
    assign mem.mem_req   = mem_req_s;
    assign mem.mem_we    = mem_we_s;
    assign mem.mem_addr  = mem_addr_s;
    assign mem.mem_wdata = mem_wdata_s;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Hit/miss statistics, free-running with natural wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if (hit_s) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (miss_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_mem_wb_cache_ctrl.sv
// Directed bench for mem_wb_cache_ctrl: memory model answers beats, expected
// load data and memory beats are queued ahead and checked as the DUT produces them.
module tb_mem_wb_cache_ctrl;

    logic clk;
    logic rst_n;

    cpu_bus_if #(.ADDR_W(32)) cpu ();
    mem_bus_if #(.ADDR_W(32)) mem ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    mem_wb_cache_ctrl #(
        .ADDR_W     (32),
        .LINES      (64),
        .LINE_WORDS (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (cpu),
        .mem      (mem)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rd[$];
    logic [31:0] mem_model [logic [31:0]];
    int          vectors     = 0;
    int          miscompares = 0;
    int          exp_hits    = 0;
    int          exp_misses  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        else return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic we, input logic [31:0] d);
        beat_t b;
        b.addr = a; b.we = we; b.wdata = d;
        exp_beats.push_back(b);
    endtask

    task automatic push_refill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) push_beat(base + 32'(4 * i), 1'b0, 32'h0);
    endtask

    // One CPU access starting at a negedge; answers memory beats until cpu_ready
    task automatic do_access(input logic we, input logic is_word, input logic [31:0] addr,
                             input logic [31:0] wdata, input int exp_lat,
                             input int stall_beat, input int abort_beat);
        int    cyc;
        int    beat;
        bit    done;
        beat_t e;
        cpu.cpu_req = 1'b1; cpu.cpu_we = we; cpu.cpu_is_word = is_word;
        cpu.cpu_addr = addr; cpu.cpu_wdata = wdata;
        cyc = 0; beat = 0; done = 0;
        while (!done && cyc < 200) begin
            #1;
            if (cpu.cpu_ready) begin
                chk("latency", 32'(cyc), 32'(exp_lat));
                if (!we) chk("rdata", cpu.cpu_rdata, exp_rd.pop_front());
                exp_hits++;
                @(posedge clk); @(negedge clk);
                cpu.cpu_req = 1'b0;
                done = 1;
            end else if (mem.mem_req && beat == abort_beat) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mem_req", 32'(mem.mem_req), 32'd0);
                chk("rst_cpu_ready", 32'(cpu.cpu_ready), 32'd0);
                exp_beats.delete();
                cpu.cpu_req = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                done = 1;
            end else begin
                if (mem.mem_req) begin
                    if (beat == stall_beat && exp_beats.size() > 0) begin
                        for (int s = 0; s < 5; s++) begin
                            chk("stall_req", 32'(mem.mem_req), 32'd1);
                            chk("stall_addr", mem.mem_addr, exp_beats[0].addr);
                            @(posedge clk); @(negedge clk); #1;
                            cyc++;
                        end
                    end
                    if (exp_beats.size() == 0) begin
                        vectors++; miscompares++;
                        $error("FAIL spurious_beat: observed addr %h expected no request", mem.mem_addr);
                    end else begin
                        e = exp_beats.pop_front();
                        chk("beat_addr", mem.mem_addr, e.addr);
                        chk("beat_we", 32'(mem.mem_we), 32'(e.we));
                        if (e.we) begin
                            chk("beat_wdata", mem.mem_wdata, e.wdata);
                            mem_model[e.addr] = e.wdata;
                        end else begin
                            mem.mem_rdata = rd_model(e.addr);
                        end
                    end
                    mem.mem_ready = 1'b1;
                    beat++;
                end
                @(posedge clk); @(negedge clk);
                mem.mem_ready = 1'b0;
                cyc++;
            end
        end
        if (!done) begin
            vectors++; miscompares++;
            $error("FAIL timeout: observed no cpu_ready after %0d cycles expected %0d", cyc, exp_lat);
            cpu.cpu_req = 1'b0;
        end
    endtask

    task automatic chk_stats();
`ifdef CACHE_STATS_EN
        chk("hit_cnt", hit_cnt, 32'(exp_hits));
        chk("miss_cnt", miss_cnt, 32'(exp_misses));
`endif
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        cpu.cpu_req = 1'b0; cpu.cpu_we = 1'b0; cpu.cpu_is_word = 1'b1;
        cpu.cpu_addr = 32'h0; cpu.cpu_wdata = 32'h0;
        mem.mem_rdata = 32'h0; mem.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_cpu_ready", 32'(cpu.cpu_ready), 32'd0);
        chk("reset_cpu_rdata", cpu.cpu_rdata, 32'h0);
        chk("reset_mem_req", 32'(mem.mem_req), 32'd0);
        chk("reset_mem_we", 32'(mem.mem_we), 32'd0);
        chk("reset_mem_addr", mem.mem_addr, 32'h0);
        chk("reset_mem_wdata", mem.mem_wdata, 32'h0);
        chk_stats();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, clean refill
        push_refill(32'h100); exp_rd.push_back(rd_model(32'h100)); exp_misses++;
        do_access(1'b0, 1'b1, 32'h100, 32'h0, 5, -1, -1);
        // Word and byte hits
        do_access(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 0, -1, -1);
        exp_rd.push_back(32'hDEADBEEF);
        do_access(1'b0, 1'b1, 32'h100, 32'h0, 0, -1, -1);
        do_access(1'b1, 1'b0, 32'h101, 32'h000000AA, 0, -1, -1);
        exp_rd.push_back(32'h000000AA);
        do_access(1'b0, 1'b0, 32'h101, 32'h0, 0, -1, -1);
        exp_rd.push_back(32'hDEADAAEF);
        do_access(1'b0, 1'b1, 32'h100, 32'h0, 0, -1, -1);
        exp_rd.push_back(32'h000000DE);
        do_access(1'b0, 1'b0, 32'h103, 32'h0, 0, -1, -1);
        exp_rd.push_back(rd_model(32'h104));
        do_access(1'b0, 1'b1, 32'h107, 32'h0, 0, -1, -1);

        // Conflict miss with dirty victim: writeback then refill
        push_beat(32'h100, 1'b1, 32'hDEADAAEF);
        for (int i = 1; i < 4; i++) push_beat(32'h100 + 32'(4 * i), 1'b1, rd_model(32'h100 + 32'(4 * i)));
        push_refill(32'h500); exp_rd.push_back(rd_model(32'h500)); exp_misses++;
        do_access(1'b0, 1'b1, 32'h500, 32'h0, 9, -1, -1);

        // Clean victim, refill stalled for 5 cycles on beat 2
        push_refill(32'h100); exp_rd.push_back(rd_model(32'h100)); exp_misses++;
        do_access(1'b0, 1'b1, 32'h100, 32'h0, 10, 2, -1);
        chk_stats();

        // Dirty the line, then reset in the middle of its writeback
        do_access(1'b1, 1'b1, 32'h108, 32'h12345678, 0, -1, -1);
        chk_stats();
        push_beat(32'h100, 1'b1, 32'hDEADAAEF);
        push_beat(32'h104, 1'b1, rd_model(32'h104));
        do_access(1'b0, 1'b1, 32'h500, 32'h0, 9, -1, 2);
        exp_hits = 0; exp_misses = 0;
        chk_stats();

        // Every line invalid after reset; the lost store is not visible
        push_refill(32'h100); exp_rd.push_back(rd_model(32'h108)); exp_misses++;
        do_access(1'b0, 1'b1, 32'h108, 32'h0, 5, -1, -1);
        exp_rd.push_back(rd_model(32'h10C));
        do_access(1'b0, 1'b1, 32'h10C, 32'h0, 0, -1, -1);
        chk_stats();
        chk("beats_left", 32'(exp_beats.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
